// File: rtl/rgmii_tx_ddr_encoder.sv
// RGMII transmit encoder: derives the DDR TX clock pattern, the 10-bit ODDR data word and the
// GMII clock-enable from one fabric clock, switching speed only at TX clock period boundaries.
module rgmii_tx_ddr_encoder #(
    parameter int DIV_10M  = 50,
    parameter int DIV_100M = 5,
    parameter int CNT_W    = 6
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [1:0] speed_i,
    input  logic [7:0] txd_i,
    input  logic       tx_en_i,
    input  logic       tx_er_i,
    output logic       clk_en_o,
    output logic [1:0] speed_o,
    output logic [1:0] tx_clk_setting_o,
    output logic [9:0] ddr_data_o
);

    typedef enum logic {START = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] N_10M   = CNT_W'(DIV_10M);
    localparam logic [CNT_W-1:0] N_100M  = CNT_W'(DIV_100M);
    localparam logic [CNT_W-1:0] N_1000M = CNT_W'(1);

    state_t           state_p0, state_nxt;
    logic [CNT_W-1:0] phase_p0, phase_nxt;
    logic [1:0]       spd_p0, spd_nxt;
    logic [7:0]       txd_p0, txd_nxt;
    logic             en_p0, en_nxt;
    logic             er_p0, er_nxt;

    logic [CNT_W-1:0] n_len;
    logic             last_phase;
    logic             first_half, second_half;
    logic             ctl1, ctl2;
    logic [3:0]       txd_hi;

    function automatic logic [CNT_W-1:0] period_len(input logic [1:0] spd);
        case (spd)
            2'b00:   return N_10M;
            2'b01:   return N_100M;
            default: return N_1000M;
        endcase
    endfunction

    // 2'b11 is folded onto 2'b10 so only three speed codes ever become active
    function automatic logic [1:0] norm_speed(input logic [1:0] spd);
        return spd[1] ? 2'b10 : spd;
    endfunction

    always_comb begin
        n_len       = period_len(spd_p0);
        last_phase  = (phase_p0 == (n_len - CNT_W'(1)));
        // Comparing half-cycle index against N keeps the duty at exactly 50% for odd N
        first_half  = ({phase_p0, 1'b0} < {1'b0, n_len});
        second_half = ({phase_p0, 1'b1} < {1'b0, n_len});
        ctl1        = first_half  ? en_p0 : (en_p0 ^ er_p0);
        ctl2        = second_half ? en_p0 : (en_p0 ^ er_p0);
        txd_hi      = spd_p0[1] ? txd_p0[7:4] : txd_p0[3:0];
    end

    always_comb begin
        state_nxt        = state_p0;
        phase_nxt        = phase_p0;
        spd_nxt          = spd_p0;
        txd_nxt          = txd_p0;
        en_nxt           = en_p0;
        er_nxt           = er_p0;
        clk_en_o         = 1'b0;
        speed_o          = 2'b00;
        tx_clk_setting_o = 2'b00;
        ddr_data_o       = '0;
        case (state_p0)
            START: begin
                state_nxt = RUN;
                spd_nxt   = norm_speed(speed_i);
                phase_nxt = '0;
                txd_nxt   = '0;
                en_nxt    = 1'b0;
                er_nxt    = 1'b0;
            end
            RUN: begin
                clk_en_o         = last_phase;
                speed_o          = spd_p0;
                tx_clk_setting_o = {second_half, first_half};
                ddr_data_o       = {txd_hi, ctl2, txd_p0[3:0], ctl1};
                if (last_phase) begin
                    phase_nxt = '0;
                    spd_nxt   = norm_speed(speed_i);
                    txd_nxt   = txd_i;
                    en_nxt    = tx_en_i;
                    er_nxt    = tx_er_i;
                end else begin
                    phase_nxt = phase_p0 + CNT_W'(1);
                end
            end
            default: state_nxt = START;
        endcase
    end

    // Stage p0: control and hold registers, all cleared immediately on reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_p0 <= START;
            phase_p0 <= '0;
            spd_p0   <= 2'b00;
            txd_p0   <= '0;
            en_p0    <= 1'b0;
            er_p0    <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            phase_p0 <= phase_nxt;
            spd_p0   <= spd_nxt;
            txd_p0   <= txd_nxt;
            en_p0    <= en_nxt;
            er_p0    <= er_nxt;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_ddr_encoder.sv
// Scoreboard bench for rgmii_tx_ddr_encoder: stimulus pushes the expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_rgmii_tx_ddr_encoder;

    logic       clk;
    logic       reset_n;
    logic [1:0] speed_in;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic       clk_en;
    logic [1:0] speed_out;
    logic [1:0] clk_set;
    logic [9:0] ddr;

    rgmii_tx_ddr_encoder #(.DIV_10M(50), .DIV_100M(5), .CNT_W(6)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .speed_i         (speed_in),
        .txd_i           (txd),
        .tx_en_i         (tx_en),
        .tx_er_i         (tx_er),
        .clk_en_o        (clk_en),
        .speed_o         (speed_out),
        .tx_clk_setting_o(clk_set),
        .ddr_data_o      (ddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ce;
        logic [1:0] sp;
        logic [1:0] st;
        logic [9:0] dd;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    logic [1:0] pat100 [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};

    function automatic logic [9:0] slow_ddr(input logic [3:0] nib, input logic en,
                                            input logic er, input logic [1:0] st);
        return {nib, (st[1] ? en : (en ^ er)), nib, (st[0] ? en : (en ^ er))};
    endfunction

    task automatic push(input logic ce, input logic [1:0] sp, input logic [1:0] st,
                        input logic [9:0] dd, input string tag);
        exp_t e;
        e.ce = ce; e.sp = sp; e.st = st; e.dd = dd; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic ce, input logic [1:0] sp, input logic [1:0] st,
                       input logic [9:0] dd, input string tag);
        @(posedge clk);
        #1;
        push(ce, sp, st, dd, tag);
    endtask

    // Monitor: the DUT presents a word every cycle, compared away from the active edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (clk_en === e.ce) passes++;
            else $display("FAIL %s clk_en: got %b expected %b", e.tag, clk_en, e.ce);
            checks++;
            if (speed_out === e.sp) passes++;
            else $display("FAIL %s speed_o: got %b expected %b", e.tag, speed_out, e.sp);
            checks++;
            if (clk_set === e.st) passes++;
            else $display("FAIL %s tx_clk_setting: got %b expected %b", e.tag, clk_set, e.st);
            checks++;
            if (ddr === e.dd) passes++;
            else $display("FAIL %s ddr_data: got %h expected %h", e.tag, ddr, e.dd);
        end
    end

    initial begin
        logic [1:0] st;
        reset_n  = 1'b0;
        speed_in = 2'b00;
        txd      = 8'h00;
        tx_en    = 1'b0;
        tx_er    = 1'b0;

        // Reset state, then one START cycle after release
        repeat (3) cyc(1'b0, 2'b00, 2'b00, 10'h000, "reset");
        reset_n  = 1'b1;
        speed_in = 2'b10;
        txd      = 8'hA5;
        tx_en    = 1'b1;

        // 1000M: first RUN cycle still shows cleared hold regs, then A5 one cycle later
        cyc(1'b1, 2'b10, 2'b01, 10'h000, "g_first");
        repeat (3) cyc(1'b1, 2'b10, 2'b01, 10'h2AB, "g_a5");
        txd      = 8'h3C;
        tx_er    = 1'b1;
        speed_in = 2'b11;
        repeat (2) cyc(1'b1, 2'b10, 2'b01, 10'h0D9, "g_er_s11");

        // 100M: mid-period input change must not reach the held word
        speed_in = 2'b01;
        tx_er    = 1'b0;
        for (int p = 0; p < 5; p++) begin
            cyc(p == 4, 2'b01, pat100[p], slow_ddr(4'hC, 1'b1, 1'b0, pat100[p]), "m100_a");
            if (p == 0) begin
                txd   = 8'h5A;
                tx_er = 1'b1;
            end
        end
        for (int p = 0; p < 5; p++)
            cyc(p == 4, 2'b01, pat100[p], slow_ddr(4'hA, 1'b1, 1'b1, pat100[p]), "m100_b");
        for (int p = 0; p < 2; p++)
            cyc(1'b0, 2'b01, pat100[p], slow_ddr(4'hA, 1'b1, 1'b1, pat100[p]), "m100_c");

        // Reset lands right after phase 2 begins: outputs drop without waiting for an edge
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        push(1'b0, 2'b00, 2'b00, 10'h000, "rst_async");
        repeat (2) cyc(1'b0, 2'b00, 2'b00, 10'h000, "rst_hold");
        reset_n = 1'b1;
        for (int p = 0; p < 5; p++)
            cyc(p == 4, 2'b01, pat100[p], 10'h000, "m100_rst");
        for (int p = 0; p < 5; p++) begin
            cyc(p == 4, 2'b01, pat100[p], slow_ddr(4'hA, 1'b1, 1'b1, pat100[p]), "m100_d");
            if (p == 0) begin
                speed_in = 2'b00;
                txd      = 8'h96;
            end
        end

        // 10M: 25 high / 25 low, ctl follows the clock level with en=er=1
        for (int p = 0; p < 50; p++) begin
            st = (p < 25) ? 2'b11 : 2'b00;
            cyc(p == 49, 2'b00, st, slow_ddr(4'h6, 1'b1, 1'b1, st), "m10_a");
        end
        for (int p = 0; p < 50; p++) begin
            st = (p < 25) ? 2'b11 : 2'b00;
            cyc(p == 49, 2'b00, st, slow_ddr(4'h6, 1'b1, 1'b1, st), "m10_b");
            if (p == 10) begin
                speed_in = 2'b10;
                txd      = 8'hA5;
                tx_er    = 1'b0;
            end
        end

        // Switch to 1000M takes effect only after the phase-49 strobe
        repeat (3) cyc(1'b1, 2'b10, 2'b01, 10'h2AB, "g_after");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
